// File: rtl/cache_repl_policy.sv
// Purpose : per-set victim selection (valid tracking + LRU / tree-PLRU / FIFO state).
// Latency : victim_way/victim_valid registered, 1 cycle after an accepted query.
// Backpr. : none; ready low during the init walk, and accesses are ignored while low.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   flush                         restart the init walk (clears valid + policy state)
//   ready                         idle; accesses are accepted only when high
//   touch/_fill/_set/_way         access (fill = miss fill, else hit); sets valid
//   inval/_set/_way               invalidate one way
//   query/_set                    victim request
//   victim_valid/victim_way       registered answer; way held until the next query
module cache_repl_policy #(
  parameter int WAYS   = 4,
  parameter int SETS   = 4,
  parameter int POLICY = 0,
  localparam int WAY_W = $clog2(WAYS),
  localparam int SET_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  output logic             ready,
  input  logic             touch,
  input  logic             touch_fill,
  input  logic [SET_W-1:0] touch_set,
  input  logic [WAY_W-1:0] touch_way,
  input  logic             inval,
  input  logic [SET_W-1:0] inval_set,
  input  logic [WAY_W-1:0] inval_way,
  input  logic             query,
  input  logic [SET_W-1:0] query_set,
  output logic             victim_valid,
  output logic [WAY_W-1:0] victim_way
);

  if (WAYS < 2 || (WAYS & (WAYS - 1)) != 0) begin : g_bad_ways
    $error("cache_repl_policy: WAYS must be a power of 2 and >= 2");
  end
  if (SETS < 2 || (SETS & (SETS - 1)) != 0) begin : g_bad_sets
    $error("cache_repl_policy: SETS must be a power of 2 and >= 2");
  end

  // ------------------------------------------------------------------
  // Init walk FSM: one set is returned to its reset state per cycle.
  // ------------------------------------------------------------------
  typedef enum logic {ST_INIT = 1'b0, ST_IDLE = 1'b1} state_t;

  state_t           state_q;
  logic [SET_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else if (flush) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else if (state_q == ST_INIT) begin
      cnt_q <= cnt_q + SET_W'(1);
      if (cnt_q == SET_W'(SETS - 1)) begin
        state_q <= ST_IDLE;
      end
    end
  end

  assign ready = (state_q == ST_IDLE);

  logic init_wr;
  logic acc_ok;
  logic touch_en;
  logic inval_en;
  logic query_en;

  assign init_wr  = (state_q == ST_INIT);
  // A flush cycle already belongs to the new walk, so accesses in it are dropped.
  assign acc_ok   = ready & ~flush;
  // Same-set touch+inval: the invalidate wins and the touch is discarded entirely.
  assign touch_en = acc_ok & touch & ~(inval & (inval_set == touch_set));
  assign inval_en = acc_ok & inval;
  assign query_en = acc_ok & query;

  // ------------------------------------------------------------------
  // Valid bits
  // ------------------------------------------------------------------
  logic [WAYS-1:0] valid_q [SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
      end
    end else begin
      if (init_wr) begin
        valid_q[cnt_q] <= '0;
      end
      if (touch_en) begin
        valid_q[touch_set][touch_way] <= 1'b1;
      end
      if (inval_en) begin
        valid_q[inval_set][inval_way] <= 1'b0;
      end
    end
  end

  // Lowest-index invalid way of the queried set (pre-update state).
  logic [WAYS-1:0]  q_valid;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;

  assign q_valid = valid_q[query_set];

  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!q_valid[w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  // Policy victim of the queried set, provided by the selected policy block.
  logic [WAY_W-1:0] pol_victim;

  // ------------------------------------------------------------------
  // Replacement state
  // ------------------------------------------------------------------
  if (POLICY == 0) begin : g_lru
    // order_q[set][slot] = way; slot 0 is least recently used.
    logic [WAY_W-1:0] order_q [SETS][WAYS];
    logic [WAY_W-1:0] t_old [WAYS];
    logic [WAY_W-1:0] t_new [WAYS];
    logic [WAY_W-1:0] i_old [WAYS];
    logic [WAY_W-1:0] i_new [WAYS];
    logic [WAY_W-1:0] t_pos;
    logic [WAY_W-1:0] i_pos;
    logic             unused_fill;

    assign unused_fill = touch_fill;

    always_comb begin
      t_old = order_q[touch_set];
      i_old = order_q[inval_set];
      t_pos = '0;
      i_pos = '0;
      // Each way occupies exactly one slot, so at most one match per search.
      for (int w = 0; w < WAYS; w++) begin
        if (t_old[w] == touch_way) t_pos = WAY_W'(w);
        if (i_old[w] == inval_way) i_pos = WAY_W'(w);
      end
      // Touch: slots above the old position slide down, way goes to MRU.
      for (int s = 0; s < WAYS - 1; s++) begin
        t_new[s] = (WAY_W'(s) < t_pos) ? t_old[s] : t_old[s + 1];
      end
      t_new[WAYS-1] = touch_way;
      // Inval: slots below the old position slide up, way goes to LRU.
      i_new[0] = inval_way;
      for (int s = 1; s < WAYS; s++) begin
        i_new[s] = (WAY_W'(s) <= i_pos) ? i_old[s - 1] : i_old[s];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s < SETS; s++) begin
          for (int w = 0; w < WAYS; w++) begin
            order_q[s][w] <= WAY_W'(w);
          end
        end
      end else begin
        if (init_wr) begin
          for (int w = 0; w < WAYS; w++) begin
            order_q[cnt_q][w] <= WAY_W'(w);
          end
        end
        if (touch_en) begin
          order_q[touch_set] <= t_new;
        end
        if (inval_en) begin
          order_q[inval_set] <= i_new;
        end
      end
    end

    assign pol_victim = order_q[query_set][0];

  end else if (POLICY == 1) begin : g_plru
    // Heap-ordered node bits; node n has children 2n+1 (left) and 2n+2 (right).
    // A 1 means the right subtree is older.
    logic [WAYS-2:0]  plru_q [SETS];
    logic [WAYS-2:0]  t_bits;
    logic [WAYS-2:0]  q_bits;
    logic [WAY_W-1:0] t_idx;
    logic [WAY_W-1:0] q_idx;
    logic [WAY_W-1:0] pv;
    logic             t_b;
    logic             unused_fill;

    assign unused_fill = touch_fill;

    always_comb begin
      t_bits = plru_q[touch_set];
      t_idx  = '0;
      t_b    = 1'b0;
      // Point every node on the path away from the touched way.
      for (int l = 0; l < WAY_W; l++) begin
        t_b           = touch_way[WAY_W-1-l];
        t_bits[t_idx] = ~t_b;
        t_idx         = WAY_W'((t_idx << 1) + WAY_W'(1) + WAY_W'(t_b));
      end

      q_bits = plru_q[query_set];
      q_idx  = '0;
      pv     = '0;
      // Follow the bits from the root; each bit is one victim address bit, MSB first.
      for (int l = 0; l < WAY_W; l++) begin
        pv[WAY_W-1-l] = q_bits[q_idx];
        q_idx         = WAY_W'((q_idx << 1) + WAY_W'(1) + WAY_W'(pv[WAY_W-1-l]));
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s < SETS; s++) begin
          plru_q[s] <= '0;
        end
      end else begin
        if (init_wr) begin
          plru_q[cnt_q] <= '0;
        end
        if (touch_en) begin
          plru_q[touch_set] <= t_bits;
        end
      end
    end

    assign pol_victim = pv;

  end else if (POLICY == 2) begin : g_fifo
    // Only miss fills advance the pointer; hits and invalidates leave it alone.
    logic [WAY_W-1:0] ptr_q [SETS];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s < SETS; s++) begin
          ptr_q[s] <= '0;
        end
      end else begin
        if (init_wr) begin
          ptr_q[cnt_q] <= '0;
        end
        if (touch_en && touch_fill) begin
          ptr_q[touch_set] <= ptr_q[touch_set] + WAY_W'(1);
        end
      end
    end

    assign pol_victim = ptr_q[query_set];

  end else begin : g_bad_policy
    $error("cache_repl_policy: POLICY must be 0 (LRU), 1 (PLRU) or 2 (FIFO)");
    assign pol_victim = '0;
  end

  // ------------------------------------------------------------------
  // Registered victim
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      victim_valid <= 1'b0;
      victim_way   <= '0;
    end else begin
      victim_valid <= query_en;
      if (query_en) begin
        victim_way <= inv_found ? inv_way : pol_victim;
      end
    end
  end

endmodule

// File: tb/tb_cache_repl_policy.sv
// Purpose : checks cache_repl_policy for all three policies driven in lock-step.
// Latency : victim checked 1 cycle after each query row.
// Backpr. : waits on ready are bounded; an expired bound is a failed check.
module tb_cache_repl_policy;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       touch;
  logic       touch_fill;
  logic [1:0] touch_set;
  logic [1:0] touch_way;
  logic       inval;
  logic [1:0] inval_set;
  logic [1:0] inval_way;
  logic       query;
  logic [1:0] query_set;

  logic       rdy [3];
  logic       vv  [3];
  logic [1:0] vw  [3];

  int pass_cnt  = 0;
  int total_cnt = 0;

  string pn [3] = '{"lru", "plru", "fifo"};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cache_repl_policy #(.WAYS(4), .SETS(4), .POLICY(0)) u_lru (
    .clk(clk), .rst(rst), .flush(flush), .ready(rdy[0]),
    .touch(touch), .touch_fill(touch_fill), .touch_set(touch_set), .touch_way(touch_way),
    .inval(inval), .inval_set(inval_set), .inval_way(inval_way),
    .query(query), .query_set(query_set),
    .victim_valid(vv[0]), .victim_way(vw[0])
  );

  cache_repl_policy #(.WAYS(4), .SETS(4), .POLICY(1)) u_plru (
    .clk(clk), .rst(rst), .flush(flush), .ready(rdy[1]),
    .touch(touch), .touch_fill(touch_fill), .touch_set(touch_set), .touch_way(touch_way),
    .inval(inval), .inval_set(inval_set), .inval_way(inval_way),
    .query(query), .query_set(query_set),
    .victim_valid(vv[1]), .victim_way(vw[1])
  );

  cache_repl_policy #(.WAYS(4), .SETS(4), .POLICY(2)) u_fifo (
    .clk(clk), .rst(rst), .flush(flush), .ready(rdy[2]),
    .touch(touch), .touch_fill(touch_fill), .touch_set(touch_set), .touch_way(touch_way),
    .inval(inval), .inval_set(inval_set), .inval_way(inval_way),
    .query(query), .query_set(query_set),
    .victim_valid(vv[2]), .victim_way(vw[2])
  );

  // One row = one cycle of stimulus; el/ep/ef = expected victim for LRU/PLRU/FIFO.
  typedef struct {
    logic       t;
    logic       f;
    logic [1:0] ts;
    logic [1:0] tw;
    logic       i;
    logic [1:0] iset;
    logic [1:0] iw;
    logic       q;
    logic [1:0] qs;
    logic [1:0] el;
    logic [1:0] ep;
    logic [1:0] ef;
  } vec_t;

  vec_t tbl  [$];
  vec_t tbl2 [$];

  function automatic vec_t blank();
    vec_t v;
    v.t = 1'b0; v.f = 1'b0; v.ts = 2'd0; v.tw = 2'd0;
    v.i = 1'b0; v.iset = 2'd0; v.iw = 2'd0;
    v.q = 1'b0; v.qs = 2'd0; v.el = 2'd0; v.ep = 2'd0; v.ef = 2'd0;
    return v;
  endfunction

  function automatic vec_t rt(input int s, input int w, input bit f);
    vec_t v;
    v = blank();
    v.t = 1'b1; v.f = f; v.ts = 2'(s); v.tw = 2'(w);
    return v;
  endfunction

  function automatic vec_t ri(input int s, input int w);
    vec_t v;
    v = blank();
    v.i = 1'b1; v.iset = 2'(s); v.iw = 2'(w);
    return v;
  endfunction

  function automatic vec_t rq(input int s, input int el, input int ep, input int ef);
    vec_t v;
    v = blank();
    v.q = 1'b1; v.qs = 2'(s); v.el = 2'(el); v.ep = 2'(ep); v.ef = 2'(ef);
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    touch = 1'b0; touch_fill = 1'b0; touch_set = 2'd0; touch_way = 2'd0;
    inval = 1'b0; inval_set = 2'd0; inval_way = 2'd0;
    query = 1'b0; query_set = 2'd0;
  endtask

  task automatic apply(input vec_t v, input string tag, input int row);
    int exp3 [3];
    @(negedge clk);
    touch = v.t; touch_fill = v.f; touch_set = v.ts; touch_way = v.tw;
    inval = v.i; inval_set = v.iset; inval_way = v.iw;
    query = v.q; query_set = v.qs;
    @(posedge clk);
    #1;
    exp3[0] = int'(v.el);
    exp3[1] = int'(v.ep);
    exp3[2] = int'(v.ef);
    for (int p = 0; p < 3; p++) begin
      check($sformatf("%s%0d_vld_%s", tag, row, pn[p]), int'(vv[p]), int'(v.q));
      if (v.q) begin
        check($sformatf("%s%0d_way_%s", tag, row, pn[p]), int'(vw[p]), exp3[p]);
      end
    end
    idle_inputs();
  endtask

  initial begin
    int low;
    vec_t v;

    rst   = 1'b1;
    flush = 1'b0;
    idle_inputs();

    // ---------------- test 1: reset values and init walk length ----------------
    repeat (2) @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      check($sformatf("rst_ready_%s", pn[p]), int'(rdy[p]), 0);
      check($sformatf("rst_vld_%s", pn[p]), int'(vv[p]), 0);
      check($sformatf("rst_way_%s", pn[p]), int'(vw[p]), 0);
    end
    query     = 1'b1;
    query_set = 2'd0;
    rst       = 1'b0;
    #1;
    low = 0;
    for (int k = 0; k < 20; k++) begin
      if (rdy[0]) break;
      low++;
      for (int p = 0; p < 3; p++) begin
        check($sformatf("init_vld_%s_c%0d", pn[p], low), int'(vv[p]), 0);
      end
      @(negedge clk);
      #1;
    end
    check("init_low_cycles", low, 4);
    for (int p = 0; p < 3; p++) begin
      check($sformatf("init_ready_%s", pn[p]), int'(rdy[p]), 1);
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < 3; p++) begin
      check($sformatf("first_vld_%s", pn[p]), int'(vv[p]), 1);
      check($sformatf("first_way_%s", pn[p]), int'(vw[p]), 0);
    end
    query = 1'b0;

    // ---------------- tests 2-5: policy tables ----------------
    // set 1: fill 0..3, hit 0, invalidate 2, refill 2
    for (int w = 0; w < 4; w++) tbl.push_back(rt(1, w, 1'b1));
    tbl.push_back(rt(1, 0, 1'b0));
    tbl.push_back(rq(1, 1, 2, 0));
    tbl.push_back(ri(1, 2));
    tbl.push_back(rq(1, 2, 2, 2));
    tbl.push_back(rt(1, 2, 1'b1));
    tbl.push_back(rq(1, 1, 1, 1));
    // set 0: fill 0..3, hit 0
    for (int w = 0; w < 4; w++) tbl.push_back(rt(0, w, 1'b1));
    tbl.push_back(rt(0, 0, 1'b0));
    tbl.push_back(rq(0, 1, 2, 0));
    // set 2: FIFO wrap, hit keeps ptr, fill advances it
    for (int w = 0; w < 4; w++) tbl.push_back(rt(2, w, 1'b1));
    tbl.push_back(rt(2, 0, 1'b0));
    tbl.push_back(rq(2, 1, 2, 0));
    tbl.push_back(rt(2, 0, 1'b1));
    tbl.push_back(rq(2, 1, 2, 1));
    // set 3: scrambled fill order
    tbl.push_back(rt(3, 3, 1'b1));
    tbl.push_back(rt(3, 1, 1'b1));
    tbl.push_back(rt(3, 0, 1'b1));
    tbl.push_back(rt(3, 2, 1'b1));
    tbl.push_back(rq(3, 3, 1, 0));
    tbl.push_back(rt(3, 1, 1'b0));
    tbl.push_back(rq(3, 3, 3, 0));
    tbl.push_back(ri(3, 3));
    tbl.push_back(rq(3, 3, 3, 3));
    tbl.push_back(rt(3, 3, 1'b1));
    tbl.push_back(rq(3, 0, 0, 1));
    // touch and inval on different sets in the same cycle: both apply
    v = rt(0, 1, 1'b0);
    v.i = 1'b1; v.iset = 2'd1; v.iw = 2'd3;
    tbl.push_back(v);
    tbl.push_back(rq(1, 3, 3, 3));
    tbl.push_back(rq(0, 2, 2, 0));
    // query on the set touched in the same cycle sees pre-touch state
    v = rt(0, 2, 1'b0);
    v.q = 1'b1; v.qs = 2'd0; v.el = 2'd2; v.ep = 2'd2; v.ef = 2'd0;
    tbl.push_back(v);
    tbl.push_back(rq(0, 3, 0, 0));

    for (int k = 0; k < tbl.size(); k++) begin
      apply(tbl[k], "tbl", k);
    end

    // ---------------- test 6: flush, restarted walk ----------------
    for (int s = 0; s < 4; s++) begin
      for (int w = 0; w < 4; w++) begin
        apply(rt(s, w, 1'b1), "fillall", s * 4 + w);
      end
    end
    @(negedge clk);
    flush = 1'b1;
    low = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (rdy[0]) break;
      low++;
      flush = (low == 2);
    end
    flush = 1'b0;
    check("flush_low_cycles", low, 6);
    for (int p = 0; p < 3; p++) begin
      check($sformatf("flush_ready_%s", pn[p]), int'(rdy[p]), 1);
    end

    for (int s = 0; s < 4; s++) tbl2.push_back(rq(s, 0, 0, 0));
    for (int w = 0; w < 3; w++) tbl2.push_back(rt(3, w, 1'b1));
    // same set, same cycle: only the invalidate of way 2 may land
    v = rt(3, 3, 1'b1);
    v.i = 1'b1; v.iset = 2'd3; v.iw = 2'd2;
    tbl2.push_back(v);
    tbl2.push_back(rq(3, 2, 2, 2));
    tbl2.push_back(rt(3, 2, 1'b1));
    tbl2.push_back(rq(3, 3, 3, 3));

    for (int k = 0; k < tbl2.size(); k++) begin
      apply(tbl2[k], "post", k);
    end

    // ---------------- rst mid-operation drops the pending victim ----------------
    @(negedge clk);
    query     = 1'b1;
    query_set = 2'd0;
    #2;
    rst = 1'b1;
    #1;
    for (int p = 0; p < 3; p++) begin
      check($sformatf("midrst_ready_%s", pn[p]), int'(rdy[p]), 0);
      check($sformatf("midrst_vld_%s", pn[p]), int'(vv[p]), 0);
      check($sformatf("midrst_way_%s", pn[p]), int'(vw[p]), 0);
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < 3; p++) begin
      check($sformatf("midrst_hold_vld_%s", pn[p]), int'(vv[p]), 0);
    end
    query = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    low = 0;
    for (int k = 0; k < 20; k++) begin
      if (rdy[0]) break;
      low++;
      @(negedge clk);
      #1;
    end
    check("midrst_init_cycles", low, 4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
